cdb_egress_channel: RTL and testbench

- Read-side (egress clock domain) half of the CDB asynchronous flit bridge. Consumes the register-array FIFO and the Johnson write pointer produced by cdb_ingress_channel. Returns its own Johnson read pointer to that block.
- Drives a CHI link-layer TX interface (flitpend/flitv/flit) under L-credit control.
- On link deactivation, returns all held credits with link flits.

---
 rtl/cdb_egress_channel_pkg.sv | 47 ++++
 rtl/cdb_lcrd_counter.sv | 36 +++
 rtl/sync_dff.sv | 23 ++
 rtl/cdb_egress_channel.sv | 128 ++++++++++++
 tb/tb_cdb_egress_channel.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_egress_channel_pkg.sv
// Shared definitions for the CDB egress channel: channel codes,
// opcode field bounds, link-flit opcode and the egress FSM encoding.
package cdb_egress_channel_pkg;

  localparam int CHANNEL_REQ = 0;
  localparam int CHANNEL_RSP = 1;
  localparam int CHANNEL_SNP = 2;
  localparam int CHANNEL_DAT = 3;

  localparam int DSU_CHI_REQ_FLIT_OPCODE_LEFT  = 3;
  localparam int DSU_CHI_REQ_FLIT_OPCODE_RIGHT = 0;
  localparam int DSU_CHI_RSP_FLIT_OPCODE_LEFT  = 4;
  localparam int DSU_CHI_RSP_FLIT_OPCODE_RIGHT = 1;
  localparam int DSU_CHI_SNP_FLIT_OPCODE_LEFT  = 4;
  localparam int DSU_CHI_SNP_FLIT_OPCODE_RIGHT = 0;
  localparam int DSU_CHI_DAT_FLIT_OPCODE_LEFT  = 5;
  localparam int DSU_CHI_DAT_FLIT_OPCODE_RIGHT = 2;

  localparam int NOC_DELAY = 2;

  localparam logic [7:0] LINK_FLIT_OPCODE = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_RETURN = 2'd1,
    ST_STOP   = 2'd2
  } egress_state_e;

  function automatic int opcode_left(input int channel);
    case (channel)
      CHANNEL_RSP: return DSU_CHI_RSP_FLIT_OPCODE_LEFT;
      CHANNEL_SNP: return DSU_CHI_SNP_FLIT_OPCODE_LEFT;
      CHANNEL_DAT: return DSU_CHI_DAT_FLIT_OPCODE_LEFT;
      default:     return DSU_CHI_REQ_FLIT_OPCODE_LEFT;
    endcase
  endfunction

  function automatic int opcode_right(input int channel);
    case (channel)
      CHANNEL_RSP: return DSU_CHI_RSP_FLIT_OPCODE_RIGHT;
      CHANNEL_SNP: return DSU_CHI_SNP_FLIT_OPCODE_RIGHT;
      CHANNEL_DAT: return DSU_CHI_DAT_FLIT_OPCODE_RIGHT;
      default:     return DSU_CHI_REQ_FLIT_OPCODE_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/cdb_lcrd_counter.sv
// Saturating L-credit counter; a grant at the ceiling with no
// concurrent send is an overflow and latches crd_ovf until reset.
module cdb_lcrd_counter #(
  parameter int MAX_CRD   = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rstn_in,
  input  logic                 crd_add,
  input  logic                 crd_sub,
  output logic [CNT_WIDTH-1:0] crd_cnt,
  output logic                 crd_ovf
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CRD);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      crd_cnt <= '0;
      crd_ovf <= 1'b0;
    end else begin
      case ({crd_add, crd_sub})
        2'b10: begin
          if (crd_cnt == MAX_CNT) crd_ovf <= 1'b1;
          else                    crd_cnt <= crd_cnt + ONE;
        end
        2'b01: begin
          if (crd_cnt != '0) crd_cnt <= crd_cnt - ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sync_dff.sv
// Two-flop synchroniser for signals crossing into the clk_in domain.
module sync_dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/cdb_egress_channel.sv
// Egress half of the CDB async flit bridge: drains the ingress FIFO onto
// a CHI TX link under L-credit control and returns credits on deactivation.
module cdb_egress_channel
  import cdb_egress_channel_pkg::*;
#(
  parameter int CDB_FIFO_DEPTH = 8,
  parameter int CDB_FLIT_WIDTH = 8,
  parameter int CHANNEL        = 0,
  parameter int CDB_MAX_CRD    = 15,
  parameter int CRD_CNT_WIDTH  = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rstn_in,
  input  logic [CDB_FIFO_DEPTH-1:0]            wptr_r_in2e,
  input  logic [CDB_FLIT_WIDTH*CDB_FIFO_DEPTH-1:0] cdb_fifo_data_in2e,
  output logic [CDB_FIFO_DEPTH-1:0]            rptr_r_e2in,
  output logic                                 tx_flitpend,
  output logic                                 tx_flitv,
  output logic [CDB_FLIT_WIDTH-1:0]            tx_flit,
  input  logic                                 txcrdv,
  input  logic                                 link_deact_req,
  output logic                                 link_deact_done,
  output logic [CRD_CNT_WIDTH-1:0]             crd_cnt,
  output logic                                 crd_ovf
);

  localparam int D         = CDB_FIFO_DEPTH;
  localparam int W         = CDB_FLIT_WIDTH;
  localparam int OPC_LEFT  = opcode_left(CHANNEL);
  localparam int OPC_RIGHT = opcode_right(CHANNEL);
  localparam int OPC_W     = OPC_LEFT - OPC_RIGHT + 1;

  egress_state_e state, next_state;
  logic [D-1:0]  sync_wptr;
  logic [D-1:0]  rptr_r;
  logic [D-1:0]  rptr_oh_r;
  logic          fifo_nempty;
  logic          send_data;
  logic          send_link;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  link_flit;

  sync_dff #(.WIDTH(D)) u_wptr_sync (
    .clk_in  (clk_in),
    .rstn_in (rstn_in),
    .d       (wptr_r_in2e),
    .q       (sync_wptr)
  );

  cdb_lcrd_counter #(.MAX_CRD(CDB_MAX_CRD), .CNT_WIDTH(CRD_CNT_WIDTH)) u_lcrd (
    .clk_in  (clk_in),
    .rstn_in (rstn_in),
    .crd_add (txcrdv),
    .crd_sub (send_data | send_link),
    .crd_cnt (crd_cnt),
    .crd_ovf (crd_ovf)
  );

  assign fifo_nempty = (rptr_r != sync_wptr);
  assign rptr_r_e2in = rptr_r;

  // Entries are written well before their pointer update is synchronised.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < D; i++) begin
      rd_data = rd_data | (cdb_fifo_data_in2e[W*i +: W] & {W{rptr_oh_r[i]}});
    end
  end

  always_comb begin
    link_flit = '0;
    link_flit[OPC_LEFT:OPC_RIGHT] = LINK_FLIT_OPCODE[OPC_W-1:0];
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      rptr_r    <= '0;
      rptr_oh_r <= D'(1);
    end else if (send_data) begin
      rptr_r    <= {rptr_r[D-2:0], ~rptr_r[D-1]};
      rptr_oh_r <= {rptr_oh_r[D-2:0], rptr_oh_r[D-1]};
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) state <= ST_RUN;
    else          state <= next_state;
  end

  // RETURN waits for the FIFO to drain first; dropping the request keeps unreturned credits.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (link_deact_req && !fifo_nempty) next_state = ST_RETURN;
      end
      ST_RETURN: begin
        if (!link_deact_req)                       next_state = ST_RUN;
        else if ((crd_cnt == '0) && !txcrdv)       next_state = ST_STOP;
      end
      ST_STOP: begin
        if (!link_deact_req) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    send_data = (state == ST_RUN) && fifo_nempty && (crd_cnt != '0);
    send_link = (state == ST_RETURN) && (crd_cnt != '0);
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      tx_flitv        <= 1'b0;
      tx_flit         <= '0;
      tx_flitpend     <= 1'b0;
      link_deact_done <= 1'b0;
    end else begin
      tx_flitv        <= send_data | send_link;
      tx_flitpend     <= (state != ST_STOP);
      link_deact_done <= (state == ST_STOP);
      if (send_data)      tx_flit <= rd_data;
      else if (send_link) tx_flit <= link_flit;
    end
  end

endmodule

// File: tb/tb_cdb_egress_channel.sv
// Scoreboard bench for cdb_egress_channel; the bench plays the ingress side
// (FIFO array + Johnson write pointer) and the link receiver.
module tb_cdb_egress_channel;

  logic        clk_in = 1'b0;
  logic        rstn_in;
  logic [7:0]  wptr_r_in2e;
  logic [63:0] cdb_fifo_data_in2e;
  logic [7:0]  rptr_r_e2in;
  logic        tx_flitpend;
  logic        tx_flitv;
  logic [7:0]  tx_flit;
  logic        txcrdv;
  logic        link_deact_req;
  logic        link_deact_done;
  logic [3:0]  crd_cnt;
  logic        crd_ovf;

  logic [7:0]  fifo_mem [8];
  int          wr_idx;
  logic [7:0]  sb [$];
  int          check_count = 0;
  int          pass_count  = 0;
  int          flit_count  = 0;
  int          cycle_count = 0;
  logic [7:0]  exp_rptr = 8'h00;
  bit          seen_ff = 0;
  bit          seen_fe = 0;

  always #5 clk_in = ~clk_in;

  cdb_egress_channel #(
    .CDB_FIFO_DEPTH (8),
    .CDB_FLIT_WIDTH (8),
    .CHANNEL        (0),
    .CDB_MAX_CRD    (15),
    .CRD_CNT_WIDTH  (4)
  ) dut (
    .clk_in             (clk_in),
    .rstn_in            (rstn_in),
    .wptr_r_in2e        (wptr_r_in2e),
    .cdb_fifo_data_in2e (cdb_fifo_data_in2e),
    .rptr_r_e2in        (rptr_r_e2in),
    .tx_flitpend        (tx_flitpend),
    .tx_flitv           (tx_flitv),
    .tx_flit            (tx_flit),
    .txcrdv             (txcrdv),
    .link_deact_req     (link_deact_req),
    .link_deact_done    (link_deact_done),
    .crd_cnt            (crd_cnt),
    .crd_ovf            (crd_ovf)
  );

  always_comb begin
    cdb_fifo_data_in2e = '0;
    for (int i = 0; i < 8; i++) cdb_fifo_data_in2e[8*i +: 8] = fifo_mem[i];
  end

  function automatic logic [7:0] jnext(input logic [7:0] p);
    return {p[6:0], ~p[7]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Ingress write: entry first, then the Johnson write pointer advances.
  task automatic applyStimulus(input logic [7:0] d);
    sb.push_back(d);
    fifo_mem[wr_idx] = d;
    wptr_r_in2e = jnext(wptr_r_in2e);
    wr_idx = (wr_idx + 1) % 8;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic grantCredits(input int n);
    txcrdv = 1'b1;
    tick(n);
    txcrdv = 1'b0;
  endtask

  task automatic doReset();
    rstn_in = 1'b0;
    txcrdv = 1'b0;
    link_deact_req = 1'b0;
    wptr_r_in2e = '0;
    wr_idx = 0;
    for (int i = 0; i < 8; i++) fifo_mem[i] = '0;
    sb.delete();
    tick(2);
    @(negedge clk_in);
    rstn_in = 1'b1;
    tick(1);
  endtask

  // Monitor: pops the scoreboard on every valid flit and follows the read pointer.
  always @(negedge clk_in) begin
    cycle_count++;
    if (!rstn_in) begin
      exp_rptr = 8'h00;
    end else begin
      if (tx_flitv) begin
        flit_count++;
        if (sb.size() == 0) checkOutput("sb_underflow", 32'd1, 32'd0);
        else checkOutput("tx_flit", {24'h0, tx_flit}, {24'h0, sb.pop_front()});
      end
      if (rptr_r_e2in != exp_rptr) begin
        checkOutput("rptr_step", {24'h0, rptr_r_e2in}, {24'h0, jnext(exp_rptr)});
        exp_rptr = rptr_r_e2in;
        if (rptr_r_e2in == 8'hFF) seen_ff = 1;
        if (rptr_r_e2in == 8'hFE && seen_ff) seen_fe = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int fc0;
    int first_v, last_v;

    // Reset state
    rstn_in = 1'b0;
    txcrdv = 1'b0;
    link_deact_req = 1'b0;
    wptr_r_in2e = '0;
    wr_idx = 0;
    for (int i = 0; i < 8; i++) fifo_mem[i] = '0;
    #2;
    checkOutput("rst_flitv", {31'h0, tx_flitv}, 32'd0);
    checkOutput("rst_flit", {24'h0, tx_flit}, 32'd0);
    checkOutput("rst_flitpend", {31'h0, tx_flitpend}, 32'd0);
    checkOutput("rst_rptr", {24'h0, rptr_r_e2in}, 32'd0);
    checkOutput("rst_crd", {28'h0, crd_cnt}, 32'd0);
    checkOutput("rst_done", {31'h0, link_deact_done}, 32'd0);
    checkOutput("rst_ovf", {31'h0, crd_ovf}, 32'd0);
    doReset();
    tick(1);
    checkOutput("run_flitpend", {31'h0, tx_flitpend}, 32'd1);

    // Two flits with three credits, back-to-back output
    grantCredits(3);
    checkOutput("t1_crd3", {28'h0, crd_cnt}, 32'd3);
    applyStimulus(8'h11);
    tick(1);
    applyStimulus(8'h22);
    lat = 1;
    while (!tx_flitv && lat < 8) begin
      tick(1);
      lat++;
    end
    checkOutput("t1_latency", lat, 32'd3);
    checkOutput("t1_rptr1", {24'h0, rptr_r_e2in}, 32'h01);
    tick(1);
    checkOutput("t1_second_v", {31'h0, tx_flitv}, 32'd1);
    checkOutput("t1_rptr3", {24'h0, rptr_r_e2in}, 32'h03);
    checkOutput("t1_crd1", {28'h0, crd_cnt}, 32'd1);
    tick(1);
    checkOutput("t1_idle", {31'h0, tx_flitv}, 32'd0);
    checkOutput("t1_sb_empty", sb.size(), 32'd0);

    // No credit: nothing leaves; a single credit releases exactly one flit
    doReset();
    fc0 = flit_count;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h40 + 8'(i));
      tick(1);
    end
    tick(6);
    checkOutput("t2_blocked", flit_count - fc0, 32'd0);
    grantCredits(1);
    tick(6);
    checkOutput("t2_one_flit", flit_count - fc0, 32'd1);
    checkOutput("t2_crd0", {28'h0, crd_cnt}, 32'd0);
    checkOutput("t2_sb_left", sb.size(), 32'd3);
    grantCredits(3);
    tick(8);
    checkOutput("t2_sb_empty", sb.size(), 32'd0);

    // Twenty flits through the depth-8 FIFO with a credit each cycle
    doReset();
    seen_ff = 0;
    seen_fe = 0;
    fc0 = flit_count;
    txcrdv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'(i * 7 + 3));
      tick(1);
    end
    txcrdv = 1'b0;
    tick(12);
    checkOutput("t3_count", flit_count - fc0, 32'd20);
    checkOutput("t3_sb_empty", sb.size(), 32'd0);
    checkOutput("t3_wrap_ff_fe", {31'h0, seen_fe}, 32'd1);
    checkOutput("t3_crd0", {28'h0, crd_cnt}, 32'd0);
    checkOutput("t3_no_ovf", {31'h0, crd_ovf}, 32'd0);

    // Credit saturation and sticky overflow
    doReset();
    grantCredits(15);
    checkOutput("t4_crd15", {28'h0, crd_cnt}, 32'd15);
    checkOutput("t4_ovf0", {31'h0, crd_ovf}, 32'd0);
    grantCredits(1);
    checkOutput("t4_sat", {28'h0, crd_cnt}, 32'd15);
    checkOutput("t4_ovf1", {31'h0, crd_ovf}, 32'd1);
    tick(5);
    checkOutput("t4_ovf_sticky", {31'h0, crd_ovf}, 32'd1);
    doReset();
    checkOutput("t4_ovf_cleared", {31'h0, crd_ovf}, 32'd0);

    // Deactivation returns five credits as link flits
    doReset();
    grantCredits(5);
    checkOutput("t5_crd5", {28'h0, crd_cnt}, 32'd5);
    for (int i = 0; i < 5; i++) sb.push_back(8'h00);
    fc0 = flit_count;
    first_v = -1;
    last_v = -1;
    link_deact_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (tx_flitv) begin
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    checkOutput("t5_link_flits", flit_count - fc0, 32'd5);
    checkOutput("t5_consecutive", last_v - first_v, 32'd4);
    checkOutput("t5_sb_empty", sb.size(), 32'd0);
    checkOutput("t5_done", {31'h0, link_deact_done}, 32'd1);
    checkOutput("t5_flitpend0", {31'h0, tx_flitpend}, 32'd0);
    checkOutput("t5_crd0", {28'h0, crd_cnt}, 32'd0);
    link_deact_req = 1'b0;
    tick(3);
    checkOutput("t5_flitpend1", {31'h0, tx_flitpend}, 32'd1);
    checkOutput("t5_done0", {31'h0, link_deact_done}, 32'd0);

    // Reset mid-burst with two flits still in the synchroniser
    doReset();
    grantCredits(4);
    applyStimulus(8'h5A);
    tick(1);
    applyStimulus(8'hA5);
    tick(1);
    rstn_in = 1'b0;
    #1;
    sb.delete();
    checkOutput("t6_flitv", {31'h0, tx_flitv}, 32'd0);
    checkOutput("t6_crd", {28'h0, crd_cnt}, 32'd0);
    checkOutput("t6_rptr", {24'h0, rptr_r_e2in}, 32'd0);
    checkOutput("t6_flitpend", {31'h0, tx_flitpend}, 32'd0);
    wptr_r_in2e = '0;
    wr_idx = 0;
    tick(1);
    checkOutput("t6_crd_edge", {28'h0, crd_cnt}, 32'd0);
    checkOutput("t6_flit_edge", {24'h0, tx_flit}, 32'd0);
    fc0 = flit_count;
    @(negedge clk_in);
    rstn_in = 1'b1;
    tick(3);
    checkOutput("t6_run", {31'h0, tx_flitpend}, 32'd1);
    checkOutput("t6_quiet", flit_count - fc0, 32'd0);
    checkOutput("t6_crd_after", {28'h0, crd_cnt}, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
